ace_snapshot_loader: RTL and testbench

Sequences the Jupiter Ace core's loader port (loader_en/addr/data/wr) from a byte stream carrying a compressed .ace snapshot. Decodes the EightyOne RLE format:
- plain byte = literal
- ED nn bb (nn=1..255) = bb repeated nn times
- ED 00 = end of image

Writes the image linearly from BASE_ADDR. It holds loader_en across the whole load so the core stays in reset and applies the register block at 0x2100. It then releases the core and reports status.

---
 rtl/ace_snapshot_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_ace_snapshot_loader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snapshot_loader.sv
// ace_snapshot_loader: decodes an EightyOne-RLE .ace snapshot stream and
// drives the Jupiter Ace loader port, holding the core in reset until the
// image is written and the tail period has elapsed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; loader_en low
// LIT   | expecting a literal byte or the ED escape marker
// ESC   | ED seen; next byte is a run count (00 = end of image)
// CNT   | run count latched; next byte is the repeated value
// RUN   | emitting the latched run, one write per cycle
// FIN   | image complete; loader_en held for TAIL cycles
// ERR   | truncated stream or address overflow; release next cycle
module ace_snapshot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h2000,
  parameter logic [15:0] MAX_ADDR  = 16'hFFFF,
  parameter int unsigned TAIL      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        loader_en,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        loader_wr,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  localparam logic [7:0] ESC_BYTE = 8'hED;
  localparam logic [7:0] TAIL_CNT = 8'(TAIL);
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_TRUNC = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LIT, S_ESC, S_CNT, S_RUN, S_FIN, S_ERR
  } state_t;

  state_t      state, state_nxt;
  // one bit wider than the address so a wrap past FFFF is seen as overflow
  logic [16:0] wr_ptr, wr_ptr_nxt;
  logic [7:0]  run_cnt, run_cnt_nxt;
  logic [7:0]  run_byte, run_byte_nxt;
  logic [7:0]  tail_cnt, tail_cnt_nxt;
  logic        trunc_pend, trunc_pend_nxt;
  logic [1:0]  err_code, err_code_nxt;
  logic        en_nxt, wr_nxt, busy_nxt, done_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  data_nxt;
  logic [1:0]  err_nxt;
  logic        accept;
  logic        ovf;

  assign in_ready = (state == S_LIT) || (state == S_ESC) || (state == S_CNT);
  assign accept   = in_valid & in_ready;
  assign ovf      = wr_ptr > {1'b0, MAX_ADDR};

  // next-state and next-output decode
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    run_cnt_nxt    = run_cnt;
    run_byte_nxt   = run_byte;
    tail_cnt_nxt   = tail_cnt;
    trunc_pend_nxt = trunc_pend;
    err_code_nxt   = err_code;
    en_nxt         = loader_en;
    wr_nxt         = 1'b0;
    busy_nxt       = busy;
    done_nxt       = done;
    addr_nxt       = loader_addr;
    data_nxt       = loader_data;
    err_nxt        = err;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt      = S_LIT;
          en_nxt         = 1'b1;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          err_nxt        = ERR_NONE;
          err_code_nxt   = ERR_NONE;
          trunc_pend_nxt = 1'b0;
          wr_ptr_nxt     = {1'b0, BASE_ADDR};
          addr_nxt       = BASE_ADDR;
        end
      end

      S_LIT: begin
        if (accept) begin
          if (in_data != ESC_BYTE) begin
            if (ovf) begin
              state_nxt    = S_ERR;
              err_code_nxt = ERR_OVF;
            end else begin
              wr_nxt     = 1'b1;
              addr_nxt   = wr_ptr[15:0];
              data_nxt   = in_data;
              wr_ptr_nxt = wr_ptr + 17'd1;
              if (in_last) begin
                state_nxt    = S_ERR;
                err_code_nxt = ERR_TRUNC;
              end
            end
          end else if (in_last) begin
            state_nxt    = S_ERR;
            err_code_nxt = ERR_TRUNC;
          end else begin
            state_nxt = S_ESC;
          end
        end
      end

      S_ESC: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            state_nxt    = S_FIN;
            tail_cnt_nxt = TAIL_CNT;
          end else if (in_last) begin
            state_nxt    = S_ERR;
            err_code_nxt = ERR_TRUNC;
          end else begin
            state_nxt   = S_CNT;
            run_cnt_nxt = in_data;
          end
        end
      end

      S_CNT: begin
        if (accept) begin
          state_nxt      = S_RUN;
          run_byte_nxt   = in_data;
          // a stream ending on the run value still gets its run written
          trunc_pend_nxt = in_last;
        end
      end

      S_RUN: begin
        if (ovf) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_OVF;
        end else begin
          wr_nxt      = 1'b1;
          addr_nxt    = wr_ptr[15:0];
          data_nxt    = run_byte;
          wr_ptr_nxt  = wr_ptr + 17'd1;
          run_cnt_nxt = run_cnt - 8'd1;
          if (run_cnt == 8'd1) begin
            if (trunc_pend) begin
              state_nxt    = S_ERR;
              err_code_nxt = ERR_TRUNC;
            end else begin
              state_nxt = S_LIT;
            end
          end
        end
      end

      S_FIN: begin
        if (tail_cnt == 8'd1) begin
          state_nxt = S_IDLE;
          en_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          err_nxt   = ERR_NONE;
        end else begin
          tail_cnt_nxt = tail_cnt - 8'd1;
        end
      end

      S_ERR: begin
        state_nxt = S_IDLE;
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        err_nxt   = err_code;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wr_ptr      <= {1'b0, BASE_ADDR};
      run_cnt     <= 8'd0;
      run_byte    <= 8'd0;
      tail_cnt    <= 8'd0;
      trunc_pend  <= 1'b0;
      err_code    <= ERR_NONE;
      loader_en   <= 1'b0;
      loader_wr   <= 1'b0;
      loader_addr <= BASE_ADDR;
      loader_data <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= ERR_NONE;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      run_cnt     <= run_cnt_nxt;
      run_byte    <= run_byte_nxt;
      tail_cnt    <= tail_cnt_nxt;
      trunc_pend  <= trunc_pend_nxt;
      err_code    <= err_code_nxt;
      loader_en   <= en_nxt;
      loader_wr   <= wr_nxt;
      loader_addr <= addr_nxt;
      loader_data <= data_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ace_snapshot_loader.sv
// Scoreboard bench for ace_snapshot_loader: a reference decoder expands each
// stream into expected writes and an expected end result; a monitor compares
// the loader port and completion status as the DUT produces them.
module tb_ace_snapshot_loader;

  localparam int TAIL = 8;

  typedef struct {
    int err;
    int addr;
    int lat;
    int stall;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic sel = 1'b0;

  logic in_ready_a, en_a, wr_a, busy_a, done_a;
  logic [15:0] addr_a;
  logic [7:0] data_a;
  logic [1:0] err_a;
  logic in_ready_b, en_b, wr_b, busy_b, done_b;
  logic [15:0] addr_b;
  logic [7:0] data_b;
  logic [1:0] err_b;

  logic in_ready_m, en_m, wr_m, busy_m, done_m;
  logic [15:0] addr_m;
  logic [7:0] data_m;
  logic [1:0] err_m;

  int checks = 0, failures = 0;
  int cyc = 0;
  int results_seen = 0;
  int stall_cnt = 0;
  int acc_edge = 0;
  bit sb_en = 1'b1;
  bit stall_en = 1'b0;
  logic done_d = 1'b0;

  logic [7:0]  stream_q[$];
  logic [23:0] exp_wr_q[$];
  res_t        exp_res_q[$];

  always #5 clk = ~clk;

  ace_snapshot_loader #(.BASE_ADDR(16'h2000), .MAX_ADDR(16'hFFFF), .TAIL(TAIL)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready_a),
    .loader_en(en_a), .loader_addr(addr_a), .loader_data(data_a),
    .loader_wr(wr_a), .busy(busy_a), .done(done_a), .err(err_a));

  ace_snapshot_loader #(.BASE_ADDR(16'hFFFE), .MAX_ADDR(16'hFFFF), .TAIL(TAIL)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready_b),
    .loader_en(en_b), .loader_addr(addr_b), .loader_data(data_b),
    .loader_wr(wr_b), .busy(busy_b), .done(done_b), .err(err_b));

  assign in_ready_m = sel ? in_ready_b : in_ready_a;
  assign en_m       = sel ? en_b       : en_a;
  assign wr_m       = sel ? wr_b       : wr_a;
  assign busy_m     = sel ? busy_b     : busy_a;
  assign done_m     = sel ? done_b     : done_a;
  assign addr_m     = sel ? addr_b     : addr_a;
  assign data_m     = sel ? data_b     : data_a;
  assign err_m      = sel ? err_b      : err_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=expired required=event (t=%0t)", name, $time);
  endtask

  // Reference decoder: walks the stream by the RLE rules and records what
  // the loader port must show, plus the final status and timing.
  function automatic void model(input int base);
    int i, n, addr, lastw, b, nn, bb, runsum, err, lat, stall;
    bit ended_ok, stop;
    res_t r;
    n = stream_q.size();
    i = 0; addr = base; lastw = base; runsum = 0;
    err = 0; lat = -1; ended_ok = 0; stop = 0;
    while (!stop && i < n) begin
      b = int'(stream_q[i]);
      if (b != 'hED) begin
        if (addr > 'hFFFF) begin err = 2; lat = 1; stop = 1; end
        else begin
          exp_wr_q.push_back({16'(addr), 8'(b)});
          lastw = addr; addr++;
          if (i == n - 1) begin err = 1; lat = 1; stop = 1; end
          i++;
        end
      end else if (i == n - 1) begin
        err = 1; lat = 1; stop = 1;
      end else begin
        nn = int'(stream_q[i + 1]);
        if (nn == 0) begin err = 0; lat = TAIL; ended_ok = 1; stop = 1; end
        else if (i + 1 == n - 1) begin err = 1; lat = 1; stop = 1; end
        else begin
          bb = int'(stream_q[i + 2]);
          runsum += nn;
          for (int k = 0; k < nn && !stop; k++) begin
            if (addr > 'hFFFF) begin err = 2; lat = -1; stop = 1; end
            else begin
              exp_wr_q.push_back({16'(addr), 8'(bb)});
              lastw = addr; addr++;
            end
          end
          if (!stop && i + 2 == n - 1) begin err = 1; lat = -1; stop = 1; end
          i += 3;
        end
      end
    end
    stall = ended_ok ? runsum + TAIL : -1;
    r.err = err; r.addr = lastw; r.lat = lat; r.stall = stall;
    exp_res_q.push_back(r);
  endfunction

  // monitor: compares every write strobe and every completion
  initial begin
    logic [23:0] e;
    res_t r;
    forever begin
      @(negedge clk);
      if (start_a || start_b) stall_cnt = 0;
      if (busy_m && !in_ready_m) stall_cnt++;
      if (in_valid && in_ready_m) acc_edge = cyc + 1;
      if (sb_en && reset_n) begin
        if (wr_m) begin
          chk("wr_with_en", int'(en_m), 1);
          if (exp_wr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wr_extra actual=%0h:%0h required=no_write", addr_m, data_m);
          end else begin
            e = exp_wr_q.pop_front();
            chk("wr_addr", int'(addr_m), int'(e[23:8]));
            chk("wr_data", int'(data_m), int'(e[7:0]));
          end
        end
        if (done_m && !done_d) begin
          if (exp_res_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_extra actual=done required=no_done");
          end else begin
            r = exp_res_q.pop_front();
            chk("done_err", int'(err_m), r.err);
            chk("done_addr", int'(addr_m), r.addr);
            chk("done_en_low", int'(en_m), 0);
            chk("done_busy_low", int'(busy_m), 0);
            if (r.lat >= 0) chk("done_latency", cyc - acc_edge, r.lat);
            if (r.stall >= 0) chk("stall_cycles", stall_cnt, r.stall);
            chk("wr_missing", exp_wr_q.size(), 0);
          end
          results_seen++;
        end
      end
      done_d = done_m;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; start_a = 1'b0; start_b = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_en"}, int'(en_m), 0);
    chk({tag, "_wr"}, int'(wr_m), 0);
    chk({tag, "_busy"}, int'(busy_m), 0);
    chk({tag, "_done"}, int'(done_m), 0);
    chk({tag, "_err"}, int'(err_m), 0);
    chk({tag, "_addr"}, int'(addr_m), sel ? 'hFFFE : 'h2000);
    chk({tag, "_ready"}, int'(in_ready_m), 0);
  endtask

  task automatic drive_stream(output bit ok);
    int budget;
    bit got, quit;
    ok = 1; quit = 0;
    for (int i = 0; i < stream_q.size() && !quit; i++) begin
      if (stall_en && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_data = stream_q[i];
      in_last = (i == stream_q.size() - 1);
      in_valid = 1'b1;
      got = 0; budget = 400;
      while (!got && !quit && budget > 0) begin
        @(negedge clk);
        if (in_ready_m) got = 1;
        else if (done_m) quit = 1;
        budget--;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (!got && !quit) begin
        fail_now("byte_accept_timeout");
        ok = 0; quit = 1;
      end
    end
  endtask

  task automatic do_load(input bit which);
    bit ok;
    int seen0, w;
    sel = which;
    exp_wr_q.delete();
    exp_res_q.delete();
    model(which ? 'hFFFE : 'h2000);
    seen0 = results_seen;
    @(posedge clk); #1;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    drive_stream(ok);
    w = 0;
    while (results_seen == seen0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (results_seen == seen0) begin
      fail_now("done_timeout");
      apply_reset();
    end
  endtask

  task automatic set_stream(input logic [7:0] b0, input int cnt, input logic [47:0] bytes);
    logic [47:0] v;
    stream_q.delete();
    v = bytes;
    stream_q.push_back(b0);
    for (int i = 1; i < cnt; i++) stream_q.push_back(v[8*(cnt-1-i) +: 8]);
  endtask

  task automatic gen_random();
    int ntok, cut;
    stream_q.delete();
    ntok = $urandom_range(1, 8);
    for (int t = 0; t < ntok; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        stream_q.push_back(8'($urandom_range(0, 236)));
      end else begin
        stream_q.push_back(8'hED);
        stream_q.push_back(8'($urandom_range(1, 6)));
        stream_q.push_back(8'($urandom));
      end
    end
    stream_q.push_back(8'hED);
    stream_q.push_back(8'h00);
    if ($urandom_range(0, 2) == 0) begin
      cut = $urandom_range(1, stream_q.size() - 1);
      while (stream_q.size() > cut) void'(stream_q.pop_back());
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit ok;
    int wr_seen;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_vals("rst_a");

    // directed streams on the BASE_ADDR=2000 instance
    set_stream(8'h41, 5, 48'h0000_4243_ED00); do_load(1'b0);
    set_stream(8'hED, 6, 48'h05AA_11ED_0000 >> 8); do_load(1'b0);
    set_stream(8'hED, 5, 48'h0001_EDED_0000 >> 8); do_load(1'b0);
    set_stream(8'h41, 3, 48'h0000_0000_ED03); do_load(1'b0);
    set_stream(8'h41, 4, 48'h0000_00ED_0377); do_load(1'b0);

    // wrap past FFFF on the BASE_ADDR=FFFE instance
    set_stream(8'h01, 5, 48'h0000_0203_ED00); do_load(1'b1);
    chk("ovf_addr_hold", int'(addr_m), 'hFFFF);

    // reset in the middle of a long run
    sel = 1'b0;
    sb_en = 1'b0;
    set_stream(8'hED, 3, 48'h0000_0000_FF00);
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    drive_stream(ok);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("run_wr_active", int'(wr_m), 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_reset_vals("rst_mid");
    wr_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_m) wr_seen++;
    end
    chk("wr_after_reset", wr_seen, 0);
    sb_en = 1'b1;
    set_stream(8'h41, 5, 48'h0000_4243_ED00); do_load(1'b0);

    // randomized streams with random input stalls
    stall_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      gen_random();
      do_load($urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
